// File: rtl/gpio_emu_pkg.sv
// Shared constants and address decode for the gpio_emu peripheral.
package gpio_emu_pkg;

    localparam int DATA_W = 32;
    localparam int GPIO_W = 8;
    localparam int ADDR_W = 12;

    localparam logic [ADDR_W-1:0] ADDR_AX1 = 12'h210;
    localparam logic [ADDR_W-1:0] ADDR_AX2 = 12'h214;
    localparam logic [ADDR_W-1:0] ADDR_CNT = 12'h218;

    localparam logic [DATA_W-1:0] RESET_VAL = '0;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_AX1,
        SEL_AX2,
        SEL_CNT
    } reg_sel_e;

    // Full-width compare so misaligned addresses like 0x211 select nothing.
    function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr == ADDR_AX1) sel = SEL_AX1;
        else if (addr == ADDR_AX2) sel = SEL_AX2;
        else if (addr == ADDR_CNT) sel = SEL_CNT;
        return sel;
    endfunction

endpackage

// File: rtl/gpio_emu_edge_det.sv
// Single-bit rising-edge detector: one sample register plus one history register.
module gpio_emu_edge_det (
    input  logic clk,
    input  logic n_reset,
    input  logic strobe,
    output logic rise
);

    logic sampled;
    logic history;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sampled <= 1'b0;
            history <= 1'b0;
        end else begin
            sampled <= strobe;
            history <= sampled;
        end
    end

    assign rise = sampled & ~history;

endmodule

// File: rtl/gpio_emu.sv
// Memory-mapped GPIO emulator: two axis registers, a latch-event counter and a
// captured GPIO input, all reached over a strobe-driven 12-bit address bus.
module gpio_emu
    import gpio_emu_pkg::*;
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic [ADDR_W-1:0] saddress,
    input  logic              srd,
    input  logic              swr,
    input  logic [DATA_W-1:0] sdata_in,
    output logic [DATA_W-1:0] sdata_out,
    input  logic [GPIO_W-1:0] gpio_in,
    input  logic              gpio_latch,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [DATA_W-1:0] gpio_in_s_insp
);

    logic [DATA_W-1:0] ax1;
    logic [DATA_W-1:0] ax2;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] gpio_in_s;
    logic              rd_edge;
    logic              wr_edge;
    logic              latch_edge;
    reg_sel_e          sel;

    gpio_emu_edge_det u_rd_edge (
        .clk     (clk),
        .n_reset (n_reset),
        .strobe  (srd),
        .rise    (rd_edge)
    );

    gpio_emu_edge_det u_wr_edge (
        .clk     (clk),
        .n_reset (n_reset),
        .strobe  (swr),
        .rise    (wr_edge)
    );

    gpio_emu_edge_det u_latch_edge (
        .clk     (clk),
        .n_reset (n_reset),
        .strobe  (gpio_latch),
        .rise    (latch_edge)
    );

    assign sel = decode_addr(saddress);

    // Reads see pre-write values because every register update here is non-blocking.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ax1       <= RESET_VAL;
            ax2       <= RESET_VAL;
            cnt       <= RESET_VAL;
            gpio_in_s <= RESET_VAL;
            sdata_out <= RESET_VAL;
            gpio_out  <= RESET_VAL[GPIO_W-1:0];
        end else begin
            if (rd_edge) begin
                case (sel)
                    SEL_AX1: sdata_out <= ax1;
                    SEL_AX2: sdata_out <= ax2;
                    SEL_CNT: sdata_out <= cnt;
                    default: sdata_out <= RESET_VAL;
                endcase
            end

            if (wr_edge && sel == SEL_AX1) ax1 <= sdata_in;
            if (wr_edge && sel == SEL_AX2) ax2 <= sdata_in;

            if (latch_edge) gpio_in_s <= {{(DATA_W-GPIO_W){1'b0}}, gpio_in};

            // A bus write to the counter overrides a same-cycle latch increment.
            if (wr_edge && sel == SEL_CNT) cnt <= sdata_in;
            else if (latch_edge)           cnt <= cnt + 32'd1;

            gpio_out <= cnt[GPIO_W-1:0];
        end
    end

    assign gpio_in_s_insp = gpio_in_s;

endmodule

// File: tb/tb_gpio_emu.sv
// Self-checking bench for gpio_emu: table of bus/latch operations plus
// hand-written sequences for simultaneous strobes, held strobes and mid-read reset.
module tb_gpio_emu;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [11:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;
    logic [7:0]  gpio_in;
    logic        gpio_latch;
    logic [7:0]  gpio_out;
    logic [31:0] gpio_in_s_insp;

    int n_cmp = 0;
    int n_err = 0;

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_LT} op_e;

    typedef struct {
        op_e         op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [7:0]  gin;
        logic [31:0] exp_rd;
        logic [31:0] exp_insp;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[$];

    gpio_emu dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_in       (sdata_in),
        .sdata_out      (sdata_out),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out),
        .gpio_in_s_insp (gpio_in_s_insp)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_rd, input logic [31:0] e_insp, input logic [7:0] e_out);
        check_output({tag, " sdata_out"}, sdata_out, e_rd);
        check_output({tag, " insp"}, gpio_in_s_insp, e_insp);
        check_output({tag, " gpio_out"}, {24'h0, gpio_out}, {24'h0, e_out});
    endtask

    // Called at a negedge: strobes high across one rising edge, then settle.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic lt);
        srd        = rd;
        swr        = wr;
        gpio_latch = lt;
        @(posedge clk);
        @(negedge clk);
        srd        = 1'b0;
        swr        = 1'b0;
        gpio_latch = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_read(input logic [11:0] addr);
        saddress = addr;
        apply_stimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic add_vec(input op_e op, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [7:0] gin, input logic [31:0] e_rd,
                           input logic [31:0] e_insp, input logic [7:0] e_out);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.gin = gin;
        v.exp_rd = e_rd; v.exp_insp = e_insp; v.exp_out = e_out;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec(OP_RD, 12'h210, 32'h0,        8'h00, 32'h0,        32'h00, 8'h00);
        add_vec(OP_RD, 12'h214, 32'h0,        8'h00, 32'h0,        32'h00, 8'h00);
        add_vec(OP_RD, 12'h218, 32'h0,        8'h00, 32'h0,        32'h00, 8'h00);
        add_vec(OP_LT, 12'h218, 32'h0,        8'hE5, 32'h0,        32'hE5, 8'h01);
        add_vec(OP_WR, 12'h210, 32'hA00,      8'hE5, 32'h0,        32'hE5, 8'h01);
        add_vec(OP_RD, 12'h210, 32'h0,        8'hE5, 32'hA00,      32'hE5, 8'h01);
        add_vec(OP_RD, 12'h218, 32'h0,        8'hE5, 32'h1,        32'hE5, 8'h01);
        add_vec(OP_LT, 12'h218, 32'h0,        8'h99, 32'h1,        32'h99, 8'h02);
        add_vec(OP_WR, 12'h214, 32'h01200000, 8'h99, 32'h1,        32'h99, 8'h02);
        add_vec(OP_RD, 12'h214, 32'h0,        8'h99, 32'h01200000, 32'h99, 8'h02);
        add_vec(OP_RD, 12'h210, 32'h0,        8'h99, 32'hA00,      32'h99, 8'h02);
        add_vec(OP_RD, 12'h218, 32'h0,        8'h99, 32'h2,        32'h99, 8'h02);
        add_vec(OP_WR, 12'h218, 32'h20,       8'h99, 32'h2,        32'h99, 8'h20);
        add_vec(OP_RD, 12'h218, 32'h0,        8'h99, 32'h20,       32'h99, 8'h20);
        add_vec(OP_LT, 12'h218, 32'h0,        8'hAB, 32'h20,       32'hAB, 8'h21);
        add_vec(OP_RD, 12'h218, 32'h0,        8'hAB, 32'h21,       32'hAB, 8'h21);
        add_vec(OP_RD, 12'hCDA, 32'h0,        8'hAB, 32'h0,        32'hAB, 8'h21);
        add_vec(OP_RD, 12'h218, 32'h0,        8'hAB, 32'h21,       32'hAB, 8'h21);
        add_vec(OP_RD, 12'h404, 32'h0,        8'hAB, 32'h0,        32'hAB, 8'h21);
        add_vec(OP_RD, 12'h214, 32'h0,        8'hAB, 32'h01200000, 32'hAB, 8'h21);
        add_vec(OP_RD, 12'h099, 32'h0,        8'hAB, 32'h0,        32'hAB, 8'h21);
        add_vec(OP_RD, 12'h210, 32'h0,        8'hAB, 32'hA00,      32'hAB, 8'h21);
        add_vec(OP_RD, 12'h166, 32'h0,        8'hAB, 32'h0,        32'hAB, 8'h21);
        add_vec(OP_RD, 12'h218, 32'h0,        8'hAB, 32'h21,       32'hAB, 8'h21);
        add_vec(OP_RD, 12'h001, 32'h0,        8'hAB, 32'h0,        32'hAB, 8'h21);
        add_vec(OP_RD, 12'h210, 32'h0,        8'hAB, 32'hA00,      32'hAB, 8'h21);
        add_vec(OP_RD, 12'h008, 32'h0,        8'hAB, 32'h0,        32'hAB, 8'h21);
        add_vec(OP_WR, 12'h404, 32'hDEADBEEF, 8'hAB, 32'h0,        32'hAB, 8'h21);
        add_vec(OP_RD, 12'h210, 32'h0,        8'hAB, 32'hA00,      32'hAB, 8'h21);
        add_vec(OP_RD, 12'h214, 32'h0,        8'hAB, 32'h01200000, 32'hAB, 8'h21);
        add_vec(OP_RD, 12'h218, 32'h0,        8'hAB, 32'h21,       32'hAB, 8'h21);
        add_vec(OP_RD, 12'h211, 32'h0,        8'hAB, 32'h0,        32'hAB, 8'h21);
        add_vec(OP_WR, 12'h218, 32'hFFFFFFFF, 8'hAB, 32'h0,        32'hAB, 8'hFF);
        add_vec(OP_RD, 12'h218, 32'h0,        8'hAB, 32'hFFFFFFFF, 32'hAB, 8'hFF);
        add_vec(OP_LT, 12'h218, 32'h0,        8'h3C, 32'hFFFFFFFF, 32'h3C, 8'h00);
        add_vec(OP_RD, 12'h218, 32'h0,        8'h3C, 32'h0,        32'h3C, 8'h00);

        n_reset    = 1'b0;
        saddress   = '0;
        srd        = 1'b0;
        swr        = 1'b0;
        sdata_in   = '0;
        gpio_in    = '0;
        gpio_latch = 1'b0;
        repeat (3) @(negedge clk);
        check_all("in_reset", 32'h0, 32'h0, 8'h00);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all("after_reset", 32'h0, 32'h0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            saddress = vecs[i].addr;
            sdata_in = vecs[i].wdata;
            gpio_in  = vecs[i].gin;
            apply_stimulus(vecs[i].op == OP_RD, vecs[i].op == OP_WR, vecs[i].op == OP_LT);
            check_all($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_insp, vecs[i].exp_out);
        end

        // Counter write and latch together: write value wins, capture still happens.
        saddress = 12'h218;
        sdata_in = 32'h5;
        gpio_in  = 8'h77;
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_all("wr_latch_same", 32'h0, 32'h77, 8'h05);
        bus_read(12'h218);
        check_output("wr_latch_cnt", sdata_out, 32'h5);

        // Latch held high for several edges counts once.
        gpio_in    = 8'h42;
        gpio_latch = 1'b1;
        repeat (6) @(negedge clk);
        gpio_latch = 1'b0;
        repeat (3) @(negedge clk);
        check_all("held_latch", 32'h5, 32'h42, 8'h06);
        bus_read(12'h218);
        check_output("held_latch_cnt", sdata_out, 32'h6);

        // Read and write of AX1 together: read returns the old contents.
        saddress = 12'h210;
        sdata_in = 32'h123;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("rd_wr_same", sdata_out, 32'hA00);
        bus_read(12'h210);
        check_output("rd_wr_after", sdata_out, 32'h123);

        // Latch plus AX2 write in one cycle: both land.
        saddress = 12'h214;
        sdata_in = 32'h0BADF00D;
        gpio_in  = 8'h5A;
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_all("wr_ax2_latch", 32'h123, 32'h5A, 8'h07);
        bus_read(12'h214);
        check_output("wr_ax2_latch_rd", sdata_out, 32'h0BADF00D);

        // Reset asserted in the middle of a held read.
        saddress = 12'h210;
        srd      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        check_all("mid_read_reset", 32'h0, 32'h0, 8'h00);
        @(negedge clk);
        srd     = 1'b0;
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(12'h210);
        check_output("post_reset_ax1", sdata_out, 32'h0);
        bus_read(12'h214);
        check_output("post_reset_ax2", sdata_out, 32'h0);
        bus_read(12'h218);
        check_output("post_reset_cnt", sdata_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
